inst_loader: RTL and testbench

Write-side counterpart of the instruction fetch path. Accepts a byte-serial program image and packs it into 32-bit little-endian words. Writes the words sequentially into the 64-entry instruction store from address 0 upward. Serves the fetch read port and holds the core in reset (cpu_rst) until the image is complete.

---
 rtl/inst_loader_pkg.sv | 16 +
 rtl/inst_loader_packer.sv | 42 ++++
 rtl/inst_loader.sv | 116 +++++++++++
 tb/tb_inst_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, widths and the NOP word.
package inst_loader_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;

    // RISC-V "addi x0, x0, 0", handy filler when building images.
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage

// File: rtl/inst_loader_packer.sv
// Assembles byte-serial input into little-endian 32-bit words.
// The completed word and its strobe are combinational from the accepting byte,
// so the parent can write the store on the same edge that takes the byte.
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              word_strobe
);

    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] pack;

    // Merge the offered byte into its lane; lanes above it are still zero in pack.
    always_comb begin
        word = pack;
        word[{byte_cnt, 3'b000} +: BYTE_W] = byte_in;
        word_strobe = accept && ((byte_cnt == 2'd3) || last);
    end

    // Advance the lane counter per accepted byte and restart after every emitted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            pack     <= '0;
        end else if (accept) begin
            if (word_strobe) begin
                byte_cnt <= 2'd0;
                pack     <= '0;
            end else begin
                byte_cnt <= byte_cnt + 2'd1;
                pack     <= word;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Write side of the instruction fetch path: packs a byte-serial image into the
// instruction store, serves the fetch read port and holds the core in reset
// until the image is complete.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORDS  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              rd_ce,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_inst,
    output logic              load_done,
    output logic              cpu_rst,
    output logic              ovf
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W:0]    wcount;
    logic               accept;
    logic               last_slot;
    logic [WORD_W-1:0]  word;
    logic               word_strobe;
    logic [WORD_W-1:0]  mem [DEPTH];

    assign accept    = byte_valid && byte_ready;
    assign last_slot = (waddr == ADDR_W'(WORDS - 1));

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .byte_in     (byte_data),
        .last        (byte_last),
        .word        (word),
        .word_strobe (word_strobe)
    );

    // State register; DONE is only left through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Finish on the edge that writes the final word, either flagged by byte_last or by filling WORDS.
    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        load_done  = 1'b0;
        cpu_rst    = 1'b1;
        case (state)
            LOAD: begin
                byte_ready = 1'b1;
                if (word_strobe && (byte_last || last_slot)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                cpu_rst   = 1'b0;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    // Write pointer and count of valid words; the count gates the read port so stale contents read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr  <= '0;
            wcount <= '0;
        end else if (word_strobe) begin
            waddr  <= waddr + 1'b1;
            wcount <= wcount + 1'b1;
        end
    end

    // Sticky flag for bytes offered once the image is complete; those bytes are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((state == DONE) && byte_valid) begin
            ovf <= 1'b1;
        end
    end

    // Store write; contents survive reset and are hidden by wcount instead.
    always_ff @(posedge clk) begin
        if (word_strobe && !rst) begin
            mem[waddr] <= word;
        end
    end

    // Asynchronous read returning zero for disabled or not-yet-written addresses.
    always_comb begin
        rd_inst = '0;
        if (rd_ce && ({1'b0, rd_addr} < wcount)) begin
            rd_inst = mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus pushes expected values, a monitor
// on the falling edge pops and compares whenever a probe is raised.
module tb_inst_loader;
    import inst_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic        rd_ce = 1'b0;
    logic [5:0]  rd_addr = 6'd0;
    logic [31:0] rd_inst;
    logic        load_done;
    logic        cpu_rst;
    logic        ovf;

    typedef struct {
        bit          is_status;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t exp_q[$];
    bit   probe = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    inst_loader #(.ADDR_W(6), .WORDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .rd_ce      (rd_ce),
        .rd_addr    (rd_addr),
        .rd_inst    (rd_inst),
        .load_done  (load_done),
        .cpu_rst    (cpu_rst),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Status word layout: {ovf, cpu_rst, load_done, byte_ready}
    localparam logic [31:0] ST_LOADING = 32'h5;
    localparam logic [31:0] ST_DONE    = 32'h2;
    localparam logic [31:0] ST_OVF     = 32'hA;

    // Monitor: compare whatever the current probe cycle shows against the head of the scoreboard.
    always @(negedge clk) begin
        if (probe) begin
            logic [31:0] act;
            chk_t        e;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("[TB] FAIL unexpected_probe: no expected entry queued");
            end else begin
                e = exp_q.pop_front();
                act = e.is_status ? {28'd0, ovf, cpu_rst, load_done, byte_ready} : rd_inst;
                n_vec++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    // Offer one byte for one cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        byte_valid = 1'b1;
        byte_data  = data;
        byte_last  = last;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Queue an expectation and raise the probe for one idle cycle.
    task automatic checkOutput(input bit is_status, input logic ce, input logic [5:0] addr,
                               input logic [31:0] exp, input string name);
        chk_t e;
        e.is_status = is_status;
        e.exp       = exp;
        e.name      = name;
        exp_q.push_back(e);
        rd_ce   = ce;
        rd_addr = addr;
        probe   = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
        rd_ce = 1'b0;
    endtask

    task automatic send_image8(input bit gaps);
        logic [7:0] img [8];
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            if (gaps && i == 7) checkOutput(1'b1, 1'b0, 6'd0, ST_LOADING, "gap_before_last_status");
            applyStimulus(img[i], i == 7);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Scenario 1: two-word image terminated by byte_last
        do_reset();
        checkOutput(1'b1, 1'b0, 6'd0, ST_LOADING, "reset_status");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0, "reset_rd0");
        send_image8(1'b0);
        checkOutput(1'b1, 1'b0, 6'd0, ST_DONE, "img8_status");
        checkOutput(1'b0, 1'b1, 6'd1, 32'h0010_0093, "img8_rd1");
        checkOutput(1'b0, 1'b1, 6'd2, 32'h0, "img8_rd2");
        checkOutput(1'b0, 1'b1, 6'd0, NOP_WORD, "img8_rd0");

        // Scenario 6: read enable gating after a full load
        checkOutput(1'b0, 1'b0, 6'd0, 32'h0, "ce0_rd0");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0000_0013, "ce1_rd0");

        // Scenario 2: partial word closed by byte_last
        do_reset();
        applyStimulus(8'hEF, 1'b0);
        applyStimulus(8'hBE, 1'b1);
        checkOutput(1'b1, 1'b0, 6'd0, ST_DONE, "partial_status");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0000_BEEF, "partial_rd0");
        checkOutput(1'b0, 1'b1, 6'd1, 32'h0, "partial_rd1_unwritten");

        // Scenario 3: full 64-word image without byte_last, then an overflow byte
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) checkOutput(1'b1, 1'b0, 6'd0, ST_LOADING, "full_before_last_status");
            applyStimulus(8'(i), 1'b0);
        end
        checkOutput(1'b1, 1'b0, 6'd0, ST_DONE, "full_status");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0302_0100, "full_rd0");
        checkOutput(1'b0, 1'b1, 6'd31, 32'h7F7E_7D7C, "full_rd31");
        checkOutput(1'b0, 1'b1, 6'd63, 32'hFFFE_FDFC, "full_rd63");
        applyStimulus(8'h55, 1'b1);
        checkOutput(1'b1, 1'b0, 6'd0, ST_OVF, "ovf_status");
        checkOutput(1'b0, 1'b1, 6'd63, 32'hFFFE_FDFC, "ovf_rd63_unchanged");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0302_0100, "ovf_rd0_unchanged");

        // Scenario 4: same 8-byte image with idle gaps between bytes
        do_reset();
        send_image8(1'b1);
        checkOutput(1'b1, 1'b0, 6'd0, ST_DONE, "gap_status");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0000_0013, "gap_rd0");
        checkOutput(1'b0, 1'b1, 6'd1, 32'h0010_0093, "gap_rd1");
        checkOutput(1'b0, 1'b1, 6'd2, 32'h0, "gap_rd2");

        // Scenario 5: reset in the middle of a load, then reload
        do_reset();
        applyStimulus(8'h13, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h93, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0000_0013, "midload_rd0");
        do_reset();
        checkOutput(1'b1, 1'b0, 6'd0, ST_LOADING, "midrst_status");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0, "midrst_rd0");
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h04, 1'b1);
        checkOutput(1'b1, 1'b0, 6'd0, ST_DONE, "reload_status");
        checkOutput(1'b0, 1'b1, 6'd0, 32'h0403_0201, "reload_rd0");
        checkOutput(1'b0, 1'b1, 6'd1, 32'h0, "reload_rd1");

        idle(2);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
